// File: rtl/tile_renderer.sv
// Walks a 16x16 tile board and streams one plot pixel per cycle to the VGA adapter.
// Optional TILE_RENDERER_SKIP_EMPTY_EN: tiles whose colour is 3'b000 are not painted.
module tile_renderer #(
    parameter int          TILE_W      = 30,
    parameter int          X_ORIGIN    = 80,
    parameter int          Y_ORIGIN    = 0,
    parameter int          MEM_LAT     = 2,
    parameter logic [2:0]  BG_COLOUR   = 3'b000,
    parameter logic [2:0]  GRID_COLOUR = 3'b111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic [7:0] mem_address,
    output logic       mem_rden,
    input  logic [2:0] mem_q,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int PW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam logic [PW-1:0] PX_LAST = PW'(TILE_W - 1);
    localparam logic [1:0]    W_LAST  = 2'(MEM_LAT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PAINT, DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      tile_q, tile_d;
    logic [PW-1:0]   px_q, px_d;
    logic [PW-1:0]   py_q, py_d;
    logic [1:0]      wcnt_q, wcnt_d;
    logic [2:0]      tcol_q, tcol_d;

    logic [7:0]      mem_address_d;
    logic            mem_rden_d;
    logic [9:0]      x_d;
    logic [8:0]      y_d;
    logic [2:0]      colour_d;
    logic            plot_d;
    logic            busy_d;
    logic            done_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tile_q      <= '0;
            px_q        <= '0;
            py_q        <= '0;
            wcnt_q      <= '0;
            tcol_q      <= '0;
            mem_address <= '0;
            mem_rden    <= 1'b0;
            x           <= '0;
            y           <= '0;
            colour      <= '0;
            plot        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            tile_q      <= tile_d;
            px_q        <= px_d;
            py_q        <= py_d;
            wcnt_q      <= wcnt_d;
            tcol_q      <= tcol_d;
            mem_address <= mem_address_d;
            mem_rden    <= mem_rden_d;
            x           <= x_d;
            y           <= y_d;
            colour      <= colour_d;
            plot        <= plot_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tile_d  = tile_q;
        px_d    = px_q;
        py_d    = py_q;
        wcnt_d  = wcnt_q;
        tcol_d  = tcol_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    tile_d  = '0;
                end
            end
            FETCH: begin
                state_d = WAIT;
                wcnt_d  = '0;
            end
            WAIT: begin
                if (wcnt_q == W_LAST) begin
                    tcol_d  = mem_q;
                    px_d    = '0;
                    py_d    = '0;
                    state_d = PAINT;
`ifdef TILE_RENDERER_SKIP_EMPTY_EN
                    if (mem_q == 3'b000) begin
                        if (tile_q == 8'hFF) begin
                            state_d = DONE;
                        end else begin
                            tile_d  = tile_q + 8'd1;
                            state_d = FETCH;
                        end
                    end
`endif
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            PAINT: begin
                if (px_q == PX_LAST) begin
                    px_d = '0;
                    if (py_q == PX_LAST) begin
                        py_d = '0;
                        // tile 255 never wraps back to 0
                        if (tile_q == 8'hFF) begin
                            state_d = DONE;
                        end else begin
                            tile_d  = tile_q + 8'd1;
                            state_d = FETCH;
                        end
                    end else begin
                        py_d = py_q + 1'b1;
                    end
                end else begin
                    px_d = px_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            tile_d  = '0;
            px_d    = '0;
            py_d    = '0;
            wcnt_d  = '0;
        end
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        mem_address_d = tile_d;
        mem_rden_d    = (state_d == FETCH);
        plot_d        = (state_d == PAINT);
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
        x_d           = '0;
        y_d           = '0;
        colour_d      = '0;
        if (plot_d) begin
            x_d = 10'(X_ORIGIN) + 10'(tile_d[3:0]) * 10'(TILE_W) + 10'(px_d);
            y_d = 9'(Y_ORIGIN) + 9'(tile_d[7:4]) * 9'(TILE_W) + 9'(py_d);
            if (px_d == '0 || py_d == '0) begin
                colour_d = GRID_COLOUR;
            end else if (tcol_d == 3'b000) begin
                colour_d = BG_COLOUR;
            end else begin
                colour_d = tcol_d;
            end
        end
    end

endmodule

// File: tb/tb_tile_renderer.sv
// Scoreboard bench for tile_renderer with TILE_W=4, MEM_LAT=1.
// Expected pixels are queued by the stimulus; a negedge monitor pops and compares.
module tb_tile_renderer;

`ifdef TILE_RENDERER_SKIP_EMPTY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] mem_address;
    logic       mem_rden;
    logic [2:0] mem_q = 3'b000;
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    tile_renderer #(
        .TILE_W (4),
        .MEM_LAT(1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .mem_address(mem_address),
        .mem_rden   (mem_rden),
        .mem_q      (mem_q),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    logic [2:0] rom [256];
    int sb_q [$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int start_cyc = 0;
    int fetch_exp = 0;
    int done_cnt = 0;
    int pix_seen = 0;
    int last_x = 0;
    int last_y = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // one-cycle BRAM; garbage on mem_q when no read is issued
    always @(posedge clock) begin
        if (mem_rden) mem_q <= rom[mem_address];
        else mem_q <= 3'($urandom);
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int pack(input int px, input int py, input int c);
        return (px << 12) | (py << 3) | c;
    endfunction

    task automatic push_tile(input int t, input int n);
        int c, px, py, col;
        c = int'(rom[t]);
        if (SKIP && c == 0) return;
        for (int k = 0; k < n; k++) begin
            px = k % 4;
            py = k / 4;
            col = (px == 0 || py == 0) ? 7 : c;
            sb_q.push_back(pack(80 + (t % 16) * 4 + px,
                                (t / 16) * 4 + py, col));
        end
    endtask

    function automatic int model_lat();
        int l = 0;
        for (int t = 0; t < 256; t++)
            l += 2 + ((SKIP && rom[t] == 3'b000) ? 0 : 16);
        return l;
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            if (plot) begin
                if (sb_q.size() == 0) begin
                    check("extra_pixel", pack(int'(x), int'(y), int'(colour)), -1);
                end else begin
                    check("pixel", pack(int'(x), int'(y), int'(colour)),
                          sb_q.pop_front());
                end
                pix_seen++;
                last_x = int'(x);
                last_y = int'(y);
            end
            if (mem_rden) begin
                check("fetch_addr", int'(mem_address), fetch_exp);
                fetch_exp++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic arm();
        sb_q.delete();
        fetch_exp = 0;
        done_cnt = 0;
        pix_seen = 0;
    endtask

    task automatic run_board(input int exp_lat, input bit poke);
        bit got;
        arm();
        for (int t = 0; t < 256; t++) push_tile(t, 16);
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 6000 && !got; i++) begin
            @(negedge clock);
            start = poke && mem_rden && (mem_address == 8'd10);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check("done_seen", int'(got), 1);
        if (got) begin
            check("done_latency", cyc - start_cyc, exp_lat);
            check("busy_at_done", int'(busy), 1);
            @(negedge clock);
            check("busy_after_done", int'(busy), 0);
            check("done_width", int'(done), 0);
        end
        repeat (3) @(negedge clock);
        #1;
        check("done_count", done_cnt, 1);
        check("queue_left", sb_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, int'(mem_address), 0);
        check({tag, "_rden"}, int'(mem_rden), 0);
        check({tag, "_x"}, int'(x), 0);
        check({tag, "_y"}, int'(y), 0);
        check({tag, "_colour"}, int'(colour), 0);
        check({tag, "_plot"}, int'(plot), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        bit hit;
        repeat (2) @(negedge clock);
        check_zero("reset");
        reset = 1'b1;

        // tile 0 red, tile 255 blue, rest empty
        for (int t = 0; t < 256; t++) rom[t] = 3'b000;
        rom[0] = 3'b100;
        rom[255] = 3'b001;
        run_board(SKIP ? 544 : 4608, 1'b0);
        check("pixel_count", pix_seen, SKIP ? 32 : 4096);
        check("last_x", last_x, 143);
        check("last_y", last_y, 63);

        // start again while busy at tile 10
        run_board(SKIP ? 544 : 4608, 1'b1);
        check("poke_pixel_count", pix_seen, SKIP ? 32 : 4096);

        // abort after 5 pixels of tile 5
        for (int t = 0; t < 256; t++) rom[t] = 3'b010;
        arm();
        for (int t = 0; t < 5; t++) push_tile(t, 16);
        push_tile(5, 5);
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clock);
            #1;
            if (pix_seen == 85) hit = 1'b1;
        end
        check("abort_reached", int'(hit), 1);
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        check("abort_plot", int'(plot), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_rden", int'(mem_rden), 0);
        repeat (20) @(negedge clock);
        #1;
        check("abort_done", done_cnt, 0);
        check("abort_queue", sb_q.size(), 0);

        // restart, then async reset during tile 3 WAIT
        arm();
        for (int t = 0; t < 3; t++) push_tile(t, 16);
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clock);
            if (mem_rden && mem_address == 8'd3) hit = 1'b1;
        end
        check("wait_reached", int'(hit), 1);
        @(posedge clock);
        #2;
        check("wait_busy", int'(busy), 1);
        reset = 1'b0;
        #1;
        check_zero("async");
        check("async_pixels", pix_seen, 48);
        check("async_queue", sb_q.size(), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // varied colours after reset release
        for (int t = 0; t < 256; t++) rom[t] = 3'(t);
        run_board(model_lat(), 1'b0);
        check("last_x_2", last_x, 143);
        check("last_y_2", last_y, 63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
